// File: rtl/jpeg_blk_pkg.sv
// Shared constants, types and zigzag scan table for the block pixel serializer.
//   DATA_WIDTH  bits per pixel
//   DEPTH       pixels per 8x8 block
//   SEQ_W       width of the sequence counter / pixel index
//   BLK_W       width of one packed block
//   state_t     serializer FSM encoding (IDLE, STREAM)
//   block_t     packed block, element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   zigzag_addr standard JPEG zigzag scan: sequence position -> element address
// Optional build macro used by the serializer: ZIGZAG_ORDER_EN.
package jpeg_blk_pkg;

    localparam int unsigned DATA_WIDTH = 12;
    localparam int unsigned DEPTH      = 64;
    localparam int unsigned SEQ_W      = 6;
    localparam int unsigned BLK_W      = DATA_WIDTH * DEPTH;

    localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] block_t;

    // Zigzag scan position -> raster element address.
    function automatic logic [SEQ_W-1:0] zigzag_addr(input logic [SEQ_W-1:0] seq);
        logic [SEQ_W-1:0] a;
        case (seq)
            6'd0:  a = 6'd0;   6'd1:  a = 6'd1;   6'd2:  a = 6'd8;   6'd3:  a = 6'd16;
            6'd4:  a = 6'd9;   6'd5:  a = 6'd2;   6'd6:  a = 6'd3;   6'd7:  a = 6'd10;
            6'd8:  a = 6'd17;  6'd9:  a = 6'd24;  6'd10: a = 6'd32;  6'd11: a = 6'd25;
            6'd12: a = 6'd18;  6'd13: a = 6'd11;  6'd14: a = 6'd4;   6'd15: a = 6'd5;
            6'd16: a = 6'd12;  6'd17: a = 6'd19;  6'd18: a = 6'd26;  6'd19: a = 6'd33;
            6'd20: a = 6'd40;  6'd21: a = 6'd48;  6'd22: a = 6'd41;  6'd23: a = 6'd34;
            6'd24: a = 6'd27;  6'd25: a = 6'd20;  6'd26: a = 6'd13;  6'd27: a = 6'd6;
            6'd28: a = 6'd7;   6'd29: a = 6'd14;  6'd30: a = 6'd21;  6'd31: a = 6'd28;
            6'd32: a = 6'd35;  6'd33: a = 6'd42;  6'd34: a = 6'd49;  6'd35: a = 6'd56;
            6'd36: a = 6'd57;  6'd37: a = 6'd50;  6'd38: a = 6'd43;  6'd39: a = 6'd36;
            6'd40: a = 6'd29;  6'd41: a = 6'd22;  6'd42: a = 6'd15;  6'd43: a = 6'd23;
            6'd44: a = 6'd30;  6'd45: a = 6'd37;  6'd46: a = 6'd44;  6'd47: a = 6'd51;
            6'd48: a = 6'd58;  6'd49: a = 6'd59;  6'd50: a = 6'd52;  6'd51: a = 6'd45;
            6'd52: a = 6'd38;  6'd53: a = 6'd31;  6'd54: a = 6'd39;  6'd55: a = 6'd46;
            6'd56: a = 6'd53;  6'd57: a = 6'd60;  6'd58: a = 6'd61;  6'd59: a = 6'd54;
            6'd60: a = 6'd47;  6'd61: a = 6'd55;  6'd62: a = 6'd62;  default: a = 6'd63;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/zigzag_addr_rom.sv
// 64-entry combinational LUT mapping a scan sequence position to the element
// address within the block (standard JPEG zigzag). Used only when the
// serializer is built with ZIGZAG_ORDER_EN.
//   seq   in   SEQ_W  sequence position 0..63
//   addr  out  SEQ_W  element address to read
import jpeg_blk_pkg::*;

module zigzag_addr_rom (
    input  logic [SEQ_W-1:0] seq,
    output logic [SEQ_W-1:0] addr
);

    assign addr = zigzag_addr(seq);

endmodule

// File: rtl/block_pixel_serializer.sv
// Read side of the 64x12-bit block buffer: accepts one packed 8x8 block per
// valid/ready handshake and streams it out as 64 pixels, one per cycle when
// not back-pressured. One active and one pending slot let the next block be
// accepted while the current one streams, so consecutive blocks have no bubble.
// Build macro ZIGZAG_ORDER_EN: pixels leave in JPEG zigzag order instead of
// raster order; pix_index is the sequence position in both builds.
//   clock      in   1           rising-edge clock
//   reset_n    in   1           asynchronous active-low reset
//   abort      in   1           synchronous flush of both slots
//   blk_valid  in   1           packed block offered
//   blk_data   in   BLK_W       packed block, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   blk_ready  out  1           block can be accepted this cycle
//   pix_valid  out  1           pixel outputs valid
//   pix_ready  in   1           consumer takes the pixel
//   pix_data   out  DATA_WIDTH  current pixel (0 when idle)
//   pix_index  out  SEQ_W       sequence position of the current pixel
//   pix_last   out  1           current pixel is position 63
//   busy       out  1           active or pending slot occupied
import jpeg_blk_pkg::*;

module block_pixel_serializer (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  abort,
    input  logic                  blk_valid,
    input  logic [BLK_W-1:0]      blk_data,
    output logic                  blk_ready,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic [SEQ_W-1:0]      pix_index,
    output logic                  pix_last,
    output logic                  busy
);

    state_t           state_q, state_n;
    block_t           active_q, active_n;
    block_t           pending_q, pending_n;
    logic             pending_full_q, pending_full_n;
    logic [SEQ_W-1:0] seq_q, seq_n;
    logic [SEQ_W-1:0] rd_addr;

    logic [DATA_WIDTH-1:0] pix_data_n;
    logic                  pix_valid_n;
    logic                  pix_last_n;
    logic                  busy_n;

    logic accept;
    logic xfer;
    logic block_end;

    // abort gates the handshake so a flushed cycle never accepts a block
    assign blk_ready = !pending_full_q && !abort;
    assign accept    = blk_valid && blk_ready;
    assign xfer      = pix_valid && pix_ready;
    assign block_end = xfer && (seq_q == SEQ_LAST);
    assign pix_index = seq_q;

    // Slot / sequence next-state logic
    always_comb begin
        state_n        = state_q;
        active_n       = active_q;
        pending_n      = pending_q;
        pending_full_n = pending_full_q;
        seq_n          = seq_q;

        if (abort) begin
            state_n        = ST_IDLE;
            pending_full_n = 1'b0;
            seq_n          = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        active_n = block_t'(blk_data);
                        state_n  = ST_STREAM;
                        seq_n    = '0;
                    end
                end
                ST_STREAM: begin
                    if (block_end) begin
                        seq_n = '0;
                        if (pending_full_q) begin
                            active_n       = pending_q;
                            pending_full_n = 1'b0;
                        end else if (accept) begin
                            // nothing pending: the incoming block goes straight to active
                            active_n = block_t'(blk_data);
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else if (xfer) begin
                        seq_n = seq_q + SEQ_W'(1);
                    end
                    // accept implies pending empty, so this never overwrites a held block
                    if (accept && !block_end) begin
                        pending_n      = block_t'(blk_data);
                        pending_full_n = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

`ifdef ZIGZAG_ORDER_EN
    zigzag_addr_rom u_zigzag_addr_rom (
        .seq  (seq_n),
        .addr (rd_addr)
    );
`else
    assign rd_addr = seq_n;
`endif

    // Output values for the next cycle, taken from the next active slot so the
    // registered pixel lines up with the registered index
    always_comb begin
        pix_valid_n = (state_n == ST_STREAM);
        pix_data_n  = pix_valid_n ? active_n[rd_addr] : '0;
        pix_last_n  = pix_valid_n && (seq_n == SEQ_LAST);
        busy_n      = pix_valid_n || pending_full_n;
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            seq_q          <= '0;
            pix_valid      <= 1'b0;
            pix_data       <= '0;
            pix_last       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_n;
            active_q       <= active_n;
            pending_q      <= pending_n;
            pending_full_q <= pending_full_n;
            seq_q          <= seq_n;
            pix_valid      <= pix_valid_n;
            pix_data       <= pix_data_n;
            pix_last       <= pix_last_n;
            busy           <= busy_n;
        end
    end

endmodule

// File: tb/tb_block_pixel_serializer.sv
// Self-checking bench for block_pixel_serializer. Accepted blocks push their
// 64 expected pixels into a scoreboard queue; the monitor pops and compares on
// each transfer. Build with ZIGZAG_ORDER_EN to expect zigzag order.
import jpeg_blk_pkg::*;

module tb_block_pixel_serializer;

    logic                  clock     = 1'b0;
    logic                  reset_n   = 1'b0;
    logic                  abort     = 1'b0;
    logic                  blk_valid = 1'b0;
    logic [BLK_W-1:0]      blk_data  = '0;
    logic                  blk_ready;
    logic                  pix_valid;
    logic                  pix_ready = 1'b1;
    logic [DATA_WIDTH-1:0] pix_data;
    logic [SEQ_W-1:0]      pix_index;
    logic                  pix_last;
    logic                  busy;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] d;
        logic [SEQ_W-1:0]      i;
        logic                  l;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   ready_mode = 0;

`ifdef ZIGZAG_ORDER_EN
    int zz[64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                   12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                   35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                   58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
`endif

    block_pixel_serializer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .abort     (abort),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_ready (blk_ready),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_index (pix_index),
        .pix_last  (pix_last),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int elem_at(input int k);
`ifdef ZIGZAG_ORDER_EN
        return zz[k];
`else
        return k;
`endif
    endfunction

    function automatic logic [BLK_W-1:0] make_block(input int base);
        logic [BLK_W-1:0] b;
        for (int j = 0; j < 64; j++) b[j*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(base + j);
        return b;
    endfunction

    // Consumer: always ready, or a 1,0,0 repeating pattern
    initial begin
        int ph = 0;
        forever begin
            @(posedge clock);
            #1;
            if (ready_mode == 0) pix_ready = 1'b1;
            else begin
                pix_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    // Monitor + scoreboard
    initial begin
        exp_t                  e;
        logic                  prev_stall = 1'b0;
        logic [DATA_WIDTH-1:0] prev_d     = '0;
        logic [SEQ_W-1:0]      prev_i     = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && pix_valid) begin
                    check("stall_data", 32'(pix_data), 32'(prev_d));
                    check("stall_index", 32'(pix_index), 32'(prev_i));
                end
                if (pix_valid && pix_ready) begin
                    if (sb.size() == 0) check("unexpected_pix", 1, 0);
                    else begin
                        e = sb.pop_front();
                        check("pix_data", 32'(pix_data), 32'(e.d));
                        check("pix_index", 32'(pix_index), 32'(e.i));
                        check("pix_last", 32'(pix_last), 32'(e.l));
                    end
                end
                if (!pix_valid) begin
                    check("idle_data", 32'(pix_data), 0);
                    check("idle_last", 32'(pix_last), 0);
                end
                prev_stall = pix_valid && !pix_ready && !abort;
                prev_d     = pix_data;
                prev_i     = pix_index;
                if (abort) sb.delete();
                if (blk_valid && blk_ready) begin
                    for (int k = 0; k < 64; k++) begin
                        e.d = DATA_WIDTH'(32'(blk_data[elem_at(k)*DATA_WIDTH +: DATA_WIDTH]));
                        e.i = SEQ_W'(k);
                        e.l = (k == 63);
                        sb.push_back(e);
                    end
                end
            end
        end
    end

    task automatic send_block(input int base);
        bit ok = 1'b0;
        @(posedge clock);
        #1;
        blk_valid = 1'b1;
        blk_data  = make_block(base);
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            if (blk_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        blk_valid = 1'b0;
        check("blk_accept", 32'(ok), 1);
    endtask

    task automatic drain(input string tag);
        bit ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clock);
            if (!pix_valid && !busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 1);
    endtask

    task automatic wait_index(input int idx, input string tag);
        bit ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clock);
            if (pix_valid && pix_index == SEQ_W'(idx)) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_valid"}, 32'(pix_valid), 0);
        check({tag, "_pix_data"},  32'(pix_data), 0);
        check({tag, "_pix_index"}, 32'(pix_index), 0);
        check({tag, "_pix_last"},  32'(pix_last), 0);
        check({tag, "_blk_ready"}, 32'(blk_ready), 1);
        check({tag, "_busy"},      32'(busy), 0);
    endtask

    initial begin
        int cnt;
        repeat (2) @(negedge clock);
        check_reset_outputs("rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // T1 single block, full rate, 1-cycle latency
        send_block(0);
        @(negedge clock);
        check("first_valid", 32'(pix_valid), 1);
        check("first_index", 32'(pix_index), 0);
        drain("t1_drain");

        // T2 back-pressure
        ready_mode = 1;
        send_block(0);
        drain("t2_drain");
        ready_mode = 0;
        repeat (3) @(posedge clock);

        // T3 back-to-back blocks, no bubble between them
        send_block(0);
        cnt = 0;
        fork
            begin
                send_block(100);
                @(negedge clock);
                check("t3_pending_blocks", 32'(blk_ready), 0);
            end
            begin
                for (int n = 0; n < 400; n++) begin
                    @(negedge clock);
                    if (!pix_valid) break;
                    cnt++;
                end
            end
        join
        check("t3_valid_cycles", 32'(cnt), 128);
        drain("t3_drain");

        // T4 abort at index 20 with a pending block and a same-cycle offer
        send_block(0);
        send_block(100);
        wait_index(19, "t4_wait19");
        @(posedge clock);
        #1;
        check("t4_index_at_abort", 32'(pix_index), 20);
        abort     = 1'b1;
        blk_valid = 1'b1;
        blk_data  = make_block(900);
        @(posedge clock);
        #1;
        abort     = 1'b0;
        blk_valid = 1'b0;
        @(negedge clock);
        check("t4_valid_after_abort", 32'(pix_valid), 0);
        check("t4_ready_after_abort", 32'(blk_ready), 1);
        check("t4_busy_after_abort", 32'(busy), 0);
        send_block(500);
        @(negedge clock);
        check("t4_restart_data", 32'(pix_data), 32'(500 + elem_at(0)));
        drain("t4_drain");

        // T6 async reset mid-stream at index 37
        send_block(0);
        wait_index(37, "t6_wait37");
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        send_block(200);
        @(negedge clock);
        check("t6_restart_index", 32'(pix_index), 0);
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
